// File: rtl/uart_rx_os16_if.sv
// Receive-side bundle of uart_rx_os16: serial line in, received word and status strobes out.
interface uart_rx_os16_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 busy;

  modport master (
    input  rx,
    output rx_data, rx_valid, frame_err, parity_err, busy
  );

  modport slave (
    output rx,
    input  rx_data, rx_valid, frame_err, parity_err, busy
  );
endinterface

// File: rtl/uart_rx_os16.sv
// 16x-oversampling UART receiver: synchronised rx, mid-bit 3-sample majority vote,
// optional parity and stop-bit checks, one-clk result strobes, single clock domain.
module uart_rx_os16 #(
  parameter int CLK_FREQ   = 1000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_os16_if.master bus
);
  localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * 16);
  localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BIT_W    = $clog2(DATA_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_BITS - 1);
  localparam logic             PAR_EN_BIT = (PARITY_EN != 0);
  localparam logic             ODD_BIT    = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic parity_calc(input logic [DATA_BITS-1:0] data, input logic odd);
    parity_calc = (^data) ^ odd;
  endfunction

  state_t               state_r, state_n;
  logic                 sync1_r, sync2_r, prev_r;
  logic [DIV_W-1:0]     div_cnt_r;
  logic [3:0]           tick_cnt_r;
  logic [BIT_W-1:0]     bit_cnt_r;
  logic [1:0]           samp_r;
  logic [DATA_BITS-1:0] shift_r, rx_data_r;
  logic                 par_r;
  logic                 rx_valid_r, frame_err_r, parity_err_r, busy_r;

  logic rx_s, fall_s, tick_s, decide_s, end_s, vote_s, par_ok_s;
  logic shift_en_s, par_ld_s, bit_clr_s, bit_inc_s, good_s, perr_s, ferr_s;

  assign rx_s     = sync2_r;
  assign fall_s   = prev_r & ~rx_s;
  assign tick_s   = (div_cnt_r == DIV_LAST);
  assign decide_s = tick_s & (tick_cnt_r == 4'd9);
  assign end_s    = tick_s & (tick_cnt_r == 4'd15);
  // Samples from ticks 7 and 8 are held; the tick-9 sample is the live line.
  assign vote_s   = (samp_r[0] & samp_r[1]) | (samp_r[0] & rx_s) | (samp_r[1] & rx_s);
  assign par_ok_s = ~PAR_EN_BIT | (par_r == parity_calc(shift_r, ODD_BIT));

  // Next-state and per-cycle datapath controls.
  always_comb begin
    state_n    = state_r;
    shift_en_s = 1'b0;
    par_ld_s   = 1'b0;
    bit_clr_s  = 1'b0;
    bit_inc_s  = 1'b0;
    good_s     = 1'b0;
    perr_s     = 1'b0;
    ferr_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (fall_s) state_n = ST_START;
        else        state_n = ST_IDLE;
      end
      ST_START: begin
        if (decide_s && vote_s) begin
          state_n = ST_IDLE;
        end else if (end_s) begin
          state_n   = ST_DATA;
          bit_clr_s = 1'b1;
        end else begin
          state_n = ST_START;
        end
      end
      ST_DATA: begin
        shift_en_s = decide_s;
        if (end_s) begin
          if (bit_cnt_r == BIT_LAST) state_n = PAR_EN_BIT ? ST_PARITY : ST_STOP;
          else                       bit_inc_s = 1'b1;
        end else begin
          state_n = ST_DATA;
        end
      end
      ST_PARITY: begin
        par_ld_s = decide_s;
        if (end_s) state_n = ST_STOP;
        else       state_n = ST_PARITY;
      end
      ST_STOP: begin
        // Leave on the decision tick so a back-to-back start edge is not missed.
        if (decide_s) begin
          state_n = ST_IDLE;
          if (!vote_s)        ferr_s = 1'b1;
          else if (!par_ok_s) perr_s = 1'b1;
          else                good_s = 1'b1;
        end else begin
          state_n = ST_STOP;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Synchroniser, edge history, state register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r      <= 1'b1;
      sync2_r      <= 1'b1;
      prev_r       <= 1'b1;
      state_r      <= ST_IDLE;
      busy_r       <= 1'b0;
      rx_valid_r   <= 1'b0;
      frame_err_r  <= 1'b0;
      parity_err_r <= 1'b0;
      rx_data_r    <= '0;
    end else begin
      sync1_r      <= bus.rx;
      sync2_r      <= sync1_r;
      prev_r       <= sync2_r;
      state_r      <= state_n;
      busy_r       <= (state_n != ST_IDLE);
      rx_valid_r   <= good_s;
      frame_err_r  <= ferr_s;
      parity_err_r <= perr_s;
      if (good_s || perr_s) rx_data_r <= shift_r;
    end
  end

  // Tick divider (re-phased on start edge), tick/bit counters, samples and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_r  <= '0;
      tick_cnt_r <= 4'd0;
      bit_cnt_r  <= '0;
      samp_r     <= 2'b00;
      shift_r    <= '0;
      par_r      <= 1'b0;
    end else begin
      if ((state_r == ST_IDLE && fall_s) || tick_s) div_cnt_r <= '0;
      else                                          div_cnt_r <= div_cnt_r + DIV_W'(1);
      if (state_r == ST_IDLE) tick_cnt_r <= 4'd0;
      else if (tick_s)        tick_cnt_r <= tick_cnt_r + 4'd1;
      if (tick_s && tick_cnt_r == 4'd7) samp_r[0] <= rx_s;
      if (tick_s && tick_cnt_r == 4'd8) samp_r[1] <= rx_s;
      if (bit_clr_s)      bit_cnt_r <= '0;
      else if (bit_inc_s) bit_cnt_r <= bit_cnt_r + BIT_W'(1);
      if (shift_en_s) shift_r <= {vote_s, shift_r[DATA_BITS-1:1]};
      if (par_ld_s)   par_r   <= vote_s;
    end
  end

  assign bus.rx_data    = rx_data_r;
  assign bus.rx_valid   = rx_valid_r;
  assign bus.frame_err  = frame_err_r;
  assign bus.parity_err = parity_err_r;
  assign bus.busy       = busy_r;
endmodule
